// File: rtl/counter_tick_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// counter_tick_ctrl_pkg
// Shared constants for the count-tick controller:
//   - default tick divider and debounce lengths
//   - direction encoding driven to the downstream 0-9 up/down counter
//   - button slot indices used when instantiating the debouncers
//   - ctr_width(): counter width needed to hold the values 0..n-1
// ---------------------------------------------------------------------------
package counter_tick_ctrl_pkg;

    localparam int unsigned TICK_DIV_DEFAULT   = 50_000_000;
    localparam int unsigned DEB_CYCLES_DEFAULT = 1_000_000;

    // Direction encoding seen by the downstream counter.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Slot of each button in the debouncer array.
    localparam int BTN_RUN = 0;
    localparam int BTN_DIR = 1;
    localparam int BTN_NUM = 2;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int unsigned ctr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer, mismatch-counter debouncer and rising-edge press
// detector for one raw push button.
//   clk     : system clock
//   srst    : synchronous active-high reset
//   btn_i   : raw asynchronous button level, active-high
//   press_o : one-cycle pulse when the debounced level goes 0->1
// ---------------------------------------------------------------------------
module btn_debounce
    import counter_tick_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic srst,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned     CNT_W    = ctr_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter tracks how long the synchronized input has disagreed with
    // the accepted level; any agreeing cycle restarts the count. The level
    // flips once DEB_CYCLES consecutive disagreeing cycles have been seen.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    // Releases (1->0) are deliberately ignored.
    assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/counter_tick_ctrl.sv
// ---------------------------------------------------------------------------
// counter_tick_ctrl
// Run/stop and direction control plus tick prescaler for a 0-9 up/down
// counter. Two debounced push buttons toggle the run state and direction;
// while running, a single-cycle enable pulse is produced every TICK_DIV
// cycles.
//   clki      : system clock, rising edge
//   reset     : synchronous active-high reset
//   btn_run   : raw button, press toggles run/stop
//   btn_dir   : raw button, press toggles count direction
//   enable    : registered one-cycle count-tick pulse
//   direction : registered direction (DIR_UP / DIR_DOWN)
//   running   : registered run status
// ---------------------------------------------------------------------------
module counter_tick_ctrl
    import counter_tick_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clki,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_dir,
    output logic enable,
    output logic direction,
    output logic running
);

    localparam int unsigned     PRE_W    = ctr_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [BTN_NUM-1:0] btn_raw;
    logic [BTN_NUM-1:0] btn_press;

    logic             running_q;
    logic             running_d;
    logic             dir_q;
    logic             dir_d;
    logic             dir_pend_q;
    logic             dir_pend_d;
    logic             dir_req;
    logic             enable_q;
    logic             enable_d;
    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] presc_d;

    assign btn_raw[BTN_RUN] = btn_run;
    assign btn_raw[BTN_DIR] = btn_dir;

    generate
        for (genvar gi = 0; gi < BTN_NUM; gi++) begin : g_btn
            btn_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_btn_debounce (
                .clk     (clki),
                .srst    (reset),
                .btn_i   (btn_raw[gi]),
                .press_o (btn_press[gi])
            );
        end
    endgenerate

    always_comb begin
        running_d = running_q ^ btn_press[BTN_RUN];

        // Gating on the next run state means a stop clears the prescaler and
        // suppresses the tick on the very edge running falls, and a start
        // begins counting on the edge running rises.
        presc_d  = '0;
        enable_d = 1'b0;
        if (running_d) begin
            if (presc_q == PRE_LAST) begin
                enable_d = 1'b1;
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end

        // A direction change is never allowed to land together with a tick;
        // it is parked for one cycle instead. Ticks are at least two cycles
        // apart, so the parked request always goes through next cycle.
        dir_req    = btn_press[BTN_DIR] | dir_pend_q;
        dir_d      = dir_q;
        dir_pend_d = 1'b0;
        if (dir_req) begin
            if (enable_d) begin
                dir_pend_d = 1'b1;
            end else begin
                dir_d = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
            end
        end
    end

    always_ff @(posedge clki) begin
        if (reset) begin
            running_q  <= 1'b0;
            dir_q      <= DIR_UP;
            dir_pend_q <= 1'b0;
            enable_q   <= 1'b0;
            presc_q    <= '0;
        end else begin
            running_q  <= running_d;
            dir_q      <= dir_d;
            dir_pend_q <= dir_pend_d;
            enable_q   <= enable_d;
            presc_q    <= presc_d;
        end
    end

    assign enable    = enable_q;
    assign direction = dir_q;
    assign running   = running_q;

endmodule

// File: tb/tb_counter_tick_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_tick_ctrl
// Directed scenarios followed by randomized button activity, with every
// cycle compared against a behavioural model kept in this bench.
// ---------------------------------------------------------------------------
module tb_counter_tick_ctrl;

    localparam int TD  = 4;
    localparam int DEB = 3;

    logic clk = 1'b0;
    logic reset;
    logic btn_run;
    logic btn_dir;
    logic enable;
    logic direction;
    logic running;

    always #5 clk = ~clk;

    counter_tick_ctrl #(
        .TICK_DIV   (TD),
        .DEB_CYCLES (DEB)
    ) dut (
        .clki      (clk),
        .reset     (reset),
        .btn_run   (btn_run),
        .btn_dir   (btn_dir),
        .enable    (enable),
        .direction (direction),
        .running   (running)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state. The debounced level of a button flips on an
    // edge when the last DEB synchronizer outputs (raw input delayed by two
    // edges) all disagree with it; a rise yields a press one edge later.
    int           edge_n     = 0;
    int           m_start    = 0;
    bit           m_run      = 0;
    bit           m_dir      = 0;
    bit           m_dir_pend = 0;
    bit           m_en       = 0;
    bit           m_ev   [2];
    bit           m_lvl  [2];
    bit [DEB+1:0] m_hist [2];

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_step();
        bit           raw [2];
        bit           new_run;
        bit           dreq;
        bit           flip;
        bit [DEB-1:0] win;
        raw[0] = btn_run;
        raw[1] = btn_dir;
        edge_n++;
        if (reset) begin
            m_run      = 0;
            m_dir      = 0;
            m_dir_pend = 0;
            m_en       = 0;
            for (int b = 0; b < 2; b++) begin
                m_ev[b]   = 0;
                m_lvl[b]  = 0;
                m_hist[b] = '0;
            end
        end else begin
            new_run = m_run ^ m_ev[0];
            if (new_run && !m_run) m_start = edge_n;
            // Ticks land on every TD-th edge counting the start edge as 1.
            m_en = new_run && (((edge_n - m_start + 1) % TD) == 0);
            dreq = m_ev[1] || m_dir_pend;
            if (dreq && m_en) begin
                m_dir_pend = 1;
            end else begin
                if (dreq) m_dir = ~m_dir;
                m_dir_pend = 0;
            end
            m_run = new_run;
            for (int b = 0; b < 2; b++) begin
                m_hist[b] = {m_hist[b][DEB:0], raw[b]};
                win       = m_hist[b][DEB+1:2];
                flip      = m_lvl[b] ? (win == '0) : (&win);
                m_ev[b]   = flip && !m_lvl[b];
                if (flip) m_lvl[b] = ~m_lvl[b];
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison against the model plus two model-free properties.
    initial begin
        bit prev_en;
        bit prev_dir;
        prev_en  = 0;
        prev_dir = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check_val("running", running, m_run);
            check_val("direction", direction, m_dir);
            check_val("enable", enable, m_en);
            check_val("en_back_to_back", enable & prev_en, 0);
            check_val("dir_change_on_tick", enable & (direction ^ prev_dir), 0);
            prev_en  = enable;
            prev_dir = direction;
        end
    end

    initial begin
        int rem [2];
        bit lvl [2];
        int guard;

        // Reset held 5 cycles with both buttons pressed.
        reset   = 1'b1;
        btn_run = 1'b1;
        btn_dir = 1'b1;
        repeat (5) @(negedge clk);
        check_val("rst_enable", enable, 0);
        check_val("rst_direction", direction, 0);
        check_val("rst_running", running, 0);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) check_val("held_run_early", running, 0);
            if (k == 6) begin
                check_val("held_run_edge6", running, 1);
                check_val("held_dir_edge6", direction, 1);
            end
        end

        // Mid-operation reset with running=1, direction=1.
        btn_run = 1'b0;
        btn_dir = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_running", running, 0);
        check_val("midrst_direction", direction, 0);
        check_val("midrst_enable", enable, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_val("midrst_stay_run", running, 0);
        check_val("midrst_stay_dir", direction, 0);

        // Run press held 10 cycles: ticks 4, 8, 12 cycles after running rises.
        btn_run = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 5) check_val("run_pre", running, 0);
            if (k == 6) check_val("run_edge6", running, 1);
            check_val("run_tick", enable, (k == 9 || k == 13 || k == 17) ? 1 : 0);
            if (k == 10) btn_run = 1'b0;
        end

        // Two-cycle glitch on the direction button.
        btn_dir = 1'b1;
        repeat (2) @(negedge clk);
        btn_dir = 1'b0;
        repeat (10) @(negedge clk);
        check_val("glitch_dir", direction, 0);

        // Direction press whose event lands on a tick edge.
        guard = 0;
        while ((((edge_n + 7 - m_start) % TD) != 0) && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        check_val("dirtick_align", guard < 16, 1);
        btn_dir = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 6) begin
                check_val("dirtick_tick", enable, 1);
                check_val("dirtick_dir_held", direction, 0);
                btn_dir = 1'b0;
            end
            if (k == 7) check_val("dirtick_dir_late", direction, 1);
        end

        // Stop press whose event lands while the prescaler holds 2.
        guard = 0;
        while ((((edge_n + 6 - m_start) % TD) != 2) && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        check_val("stop_align", guard < 16, 1);
        btn_run = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 5) check_val("stop_run_pre", running, 1);
            if (k == 6) begin
                check_val("stop_running", running, 0);
                btn_run = 1'b0;
            end
            if (k >= 6) check_val("stop_no_tick", enable, 0);
        end

        // Randomized button activity with occasional resets.
        rem[0] = 0;
        rem[1] = 0;
        lvl[0] = 0;
        lvl[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            for (int b = 0; b < 2; b++) begin
                if (rem[b] == 0) begin
                    lvl[b] = ~lvl[b];
                    rem[b] = lvl[b] ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 14));
                end else begin
                    rem[b]--;
                end
            end
            btn_run = lvl[0];
            btn_dir = lvl[1];
        end
        reset   = 1'b0;
        btn_run = 1'b0;
        btn_dir = 1'b0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_tick_ctrl.md
COUNTER_TICK_CTRL -- requirements
Module: counter_tick_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per count tick; legal range >= 2.
REQ-002 Parameter DEB_CYCLES, default 1000000, consecutive stable cycles required to accept a button level; legal range >= 1.
REQ-003 Port clki, input, 1, sole clock; all logic on rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port btn_run, input, 1, raw asynchronous push button, active-high; press toggles run/stop.
REQ-006 Port btn_dir, input, 1, raw asynchronous push button, active-high; press toggles count direction.
REQ-007 Port enable, output, 1, registered single-cycle count-tick pulse to the downstream 0-9 up/down counter.
REQ-008 Port direction, output, 1, registered; 0 = count up, 1 = count down.
REQ-009 Port running, output, 1, registered run status.

Function
REQ-010 Each button SHALL pass through a two-flop synchronizer before any other use.
REQ-011 Each button SHALL have its own debouncer: a mismatch counter that increments on every cycle where the synchronized level differs from the debounced level, and clears on any cycle where they match.
REQ-012 The debounced level SHALL flip, and the mismatch counter SHALL clear, on the edge where the counter equals DEB_CYCLES-1 and a mismatch is still present.
REQ-013 A press event SHALL be a one-cycle pulse on a 0->1 transition of the debounced level; 1->0 transitions generate no event.
REQ-014 A press event on btn_run SHALL toggle running on the next rising edge; a press event on btn_dir SHALL toggle direction on the next rising edge.
REQ-015 Latency: with a raw level change first sampled on edge 1 and held, the toggle SHALL appear on edge DEB_CYCLES+3.
REQ-016 Glitches shorter than DEB_CYCLES synchronized cycles SHALL produce no event.
REQ-017 Simultaneous events on both buttons SHALL be processed independently in the same cycle.
REQ-018 The prescaler SHALL be held at 0 and enable SHALL be 0 while running is 0.
REQ-019 While running is 1, the prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; enable SHALL be high for exactly one cycle each wrap.
REQ-020 The first enable pulse SHALL be high in the TICK_DIV-th cycle after running rises; subsequent pulses SHALL occur every TICK_DIV cycles.
REQ-021 When running falls, the prescaler SHALL clear and enable SHALL be 0 on that same edge, with no partial tick.
REQ-022 A direction toggle SHALL NOT disturb the prescaler phase.
REQ-023 Direction SHALL never change in the same cycle that enable is high: a direction press coinciding with a tick SHALL be applied one cycle later.

Reset
REQ-024 On reset the following SHALL be 0: synchronizers, debounced levels, mismatch counters, prescaler, enable, direction and running.
REQ-025 Reset SHALL take priority over every event in the same cycle.
REQ-026 A button held through reset SHALL register as a press after DEB_CYCLES+3 edges following reset release.

Structure
REQ-027 Default TICK_DIV and DEB_CYCLES values and the direction encoding constants (UP=0, DOWN=1) SHALL live in the shared counter package.
REQ-028 Synchronizer, debouncer and press-edge logic SHALL be one sub-module, btn_debounce, instantiated twice.
REQ-029 Counter widths SHALL be derived from the parameters with clog2.

Verification (TICK_DIV=4, DEB_CYCLES=3)
REQ-030 Reset scenario: hold reset for 5 cycles with both buttons high -> all outputs 0; after release, running=1 and direction=1 appear on edge 6.
REQ-031 Run scenario: press btn_run for 10 cycles -> running=1 on edge 6; enable pulses in cycles 4, 8 and 12 after that; enable is never high for 2 consecutive cycles.
REQ-032 Glitch scenario: btn_dir high for 2 cycles, then low -> direction stays 0.
REQ-033 Direction-on-tick scenario: press btn_dir timed so its event coincides with an enable pulse -> direction toggles one cycle after the pulse; tick spacing stays 4.
REQ-034 Stop scenario: a second btn_run press while prescaler=2 -> running=0 and prescaler=0 on the same edge; no enable pulse follows.
REQ-035 Mid-operation reset: assert reset while running=1 and direction=1 -> all outputs 0 on the next edge and stay 0 with buttons released.
